core_output_recv: RTL and testbench
===================================

CORE_OUTPUT_RECV -- requirements
Module: core_output_recv

Interface
REQ-001 Parameter CORE_ID, default 0, 8-bit core index placed in the packet header.
REQ-002 Parameter N_WORDS, default 16, number of 16-bit result words per core output.
REQ-003 CLK  input  1  single clock; all logic on posedge CLK.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 core_out_ready  input  1  core buffer holds a result.
REQ-006 core_out_ctx_num  input  1  context of the pending result; valid while core_out_ready=1.
REQ-007 core_out_seq_num  input  1  sequence bit of the pending result; valid while core_out_ready=1.
REQ-008 core_out_start  input  1  one-cycle marker; data words follow from the next cycle.
REQ-009 core_dout  input  16  result word stream from the core buffer.
REQ-010 rd_en  output  1  one-cycle read request to the core buffer.
REQ-011 out_data  output  16  packet word, first-word-fall-through.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_first  output  1  out_data is the header word.
REQ-014 out_last  output  1  out_data is the final data word.
REQ-015 out_rd  input  1  downstream consumes the word when out_valid=1 and out_rd=1.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT_START, RECV, SEND_HDR and SEND_DATA.
REQ-018 IDLE: core_out_ready=1 -> latch ctx_num and seq_num, go to REQ.
REQ-019 REQ: rd_en=1 for exactly this one cycle, then go to WAIT_START.
REQ-020 rd_en SHALL be 0 in every other state; core_out_ready is ignored outside IDLE, so no re-request occurs while the core deasserts ready late.
REQ-021 WAIT_START: core_out_start=1 -> go to RECV with word counter 0.
REQ-022 RECV: capture core_dout into a local N_WORDS x 16 buffer every cycle, with no gaps.
REQ-023 RECV: word 0 SHALL be captured the cycle after core_out_start was sampled; exit to SEND_HDR after word N_WORDS-1.
REQ-024 Header word SHALL be {seq_num, ctx_num, 6'b0, CORE_ID[7:0]}.
REQ-025 SEND_HDR: out_valid=1, out_first=1, out_data=header; on out_rd go to SEND_DATA with read index 0.
REQ-026 SEND_DATA: out_data=buffer[index], out_valid=1; index advances only on out_rd.
REQ-027 SEND_DATA: out_last=1 while index=N_WORDS-1; a consume at that index returns the FSM to IDLE.
REQ-028 out_valid SHALL rise the cycle after the last word is captured.
REQ-029 out_data and out_valid SHALL hold stable while out_valid=1 and out_rd=0, for any number of cycles.
REQ-030 out_rd while out_valid=0 SHALL be ignored.
REQ-031 In the returning cycle, IDLE is entered first; a ready core is requested from the next cycle, giving a minimum gap of one cycle.
REQ-032 core_out_start sampled outside WAIT_START SHALL set err and cause no state change.
REQ-033 err SHALL clear only on reset.
REQ-034 The word counter and read index SHALL be log2(N_WORDS) bits wide and wrap to 0 on exit.

Reset
REQ-035 rst_n=0 at a clock edge SHALL force the FSM to IDLE and clear the word counter and read index.
REQ-036 During reset, rd_en, out_valid, out_first, out_last and err SHALL be 0; buffer contents are not cleared.
REQ-037 A reset mid-packet (RECV or SEND_*) SHALL discard the partial packet and issue no rd_en in the reset cycle.
REQ-038 Resetting mid-transfer does not resynchronise the core buffer; the system resets both together.

Structure
REQ-039 Header field positions and N_WORDS default SHALL live in the shared sha256 header/package next to the existing core constants.
REQ-040 The local buffer SHALL be one sub-module, core_recv_ram: a 16-bit, N_WORDS-deep distributed RAM with 1 write port and 1 asynchronous read port.

Verification
REQ-041 Ready=1 (ctx=1, seq=0), start 3 cycles after rd_en, words 0x1000..0x100F -> single rd_en pulse, then header 0x4000|CORE_ID and data 0x1000..0x100F with out_rd=1, out_last on 0x100F.
REQ-042 Out_rd toggled 1/0 randomly -> every word held stable, delivered exactly once, in order.
REQ-043 Ready held high 2 cycles after rd_en -> exactly one rd_en per packet; back-to-back packets have a ≥1-cycle gap.
REQ-044 Core_out_start pulsed in IDLE -> err=1, no output.
REQ-045 Rst_n low at RECV word 7 -> outputs 0 next cycle; a following clean packet passes intact.
REQ-046 Core_out_ctx_num=0/1 with seq=1/0 -> header bits [15:14] match the values latched at request time.

Source files
------------

// File: rtl/core_output_recv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_output_recv_pkg
// Brief    : Shared constants, FSM encoding and header helper for the core
//            output receiver.
// Revision : 1.0 - initial release
// ============================================================================
package core_output_recv_pkg;

    // Default number of 16-bit result words per core output
    localparam int N_WORDS_DEFAULT = 16;

    // Header word field positions
    localparam int HDR_SEQ_BIT = 15;
    localparam int HDR_CTX_BIT = 14;
    localparam int HDR_ID_MSB  = 7;
    localparam int HDR_ID_LSB  = 0;

    // Receiver FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQ        = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_RECV       = 3'd3,
        ST_SEND_HDR   = 3'd4,
        ST_SEND_DATA  = 3'd5
    } recv_state_t;

    // Header layout: {seq, ctx, 6'b0, core_id}
    function automatic logic [15:0] make_header(input logic       seq,
                                                input logic       ctx,
                                                input logic [7:0] core_id);
        logic [15:0] hdr;
        hdr                         = 16'h0000;
        hdr[HDR_SEQ_BIT]            = seq;
        hdr[HDR_CTX_BIT]            = ctx;
        hdr[HDR_ID_MSB:HDR_ID_LSB]  = core_id;
        return hdr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_recv_ram.sv
`default_nettype none
// ============================================================================
// Module   : core_recv_ram
// Brief    : Small distributed RAM, one synchronous write port and one
//            asynchronous read port. Contents are never cleared.
// Revision : 1.0 - initial release
// ============================================================================
module core_recv_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read keeps the output word fall-through with no latency
    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/core_output_recv.sv
`default_nettype none
// ============================================================================
// Module   : core_output_recv
// Brief    : Requests one result from a core buffer, captures N_WORDS words
//            into a local RAM and replays them as a header + data packet on
//            a first-word-fall-through interface.
// Revision : 1.0 - initial release
// ============================================================================
module core_output_recv
    import core_output_recv_pkg::*;
#(
    parameter logic [7:0] CORE_ID = 8'd0,
    parameter int         N_WORDS = N_WORDS_DEFAULT
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        core_out_ready,
    input  logic        core_out_ctx_num,
    input  logic        core_out_seq_num,
    input  logic        core_out_start,
    input  logic [15:0] core_dout,
    output logic        rd_en,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_first,
    output logic        out_last,
    input  logic        out_rd,
    output logic        err
);

    localparam int              IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    recv_state_t      state;
    recv_state_t      state_next;
    logic [IDX_W-1:0] wr_cnt;
    logic [IDX_W-1:0] rd_idx;
    logic             ctx_lat;
    logic             seq_lat;
    logic             err_q;
    logic             ram_we;
    logic [15:0]      ram_rdata;

    assign ram_we = (state == ST_RECV);

    core_recv_ram #(
        .DEPTH  (N_WORDS),
        .ADDR_W (IDX_W),
        .DATA_W (16)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .waddr (wr_cnt),
        .wdata (core_dout),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; core_out_start only matters in WAIT_START
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:       if (core_out_ready)     state_next = ST_REQ;
            ST_REQ:                                state_next = ST_WAIT_START;
            ST_WAIT_START: if (core_out_start)     state_next = ST_RECV;
            ST_RECV:       if (wr_cnt == LAST_IDX) state_next = ST_SEND_HDR;
            ST_SEND_HDR:   if (out_rd)             state_next = ST_SEND_DATA;
            ST_SEND_DATA:  if (out_rd && (rd_idx == LAST_IDX)) state_next = ST_IDLE;
            default:                               state_next = ST_IDLE;
        endcase
    end

    // Word counter, read index and sticky protocol error
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_idx <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ST_RECV) begin
                wr_cnt <= (wr_cnt == LAST_IDX) ? '0 : wr_cnt + 1'b1;
            end
            if ((state == ST_SEND_HDR) && out_rd) begin
                rd_idx <= '0;
            end else if ((state == ST_SEND_DATA) && out_rd) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            end
            if (core_out_start && (state != ST_WAIT_START)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Context and sequence bits are captured at request time for the header
    always_ff @(posedge CLK) begin
        if ((state == ST_IDLE) && core_out_ready) begin
            ctx_lat <= core_out_ctx_num;
            seq_lat <= core_out_seq_num;
        end
    end

    // Outputs; forced low while reset is asserted so no request escapes
    always_comb begin
        rd_en     = 1'b0;
        out_data  = 16'h0000;
        out_valid = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        err       = 1'b0;
        if (rst_n) begin
            err = err_q;
            case (state)
                ST_REQ: begin
                    rd_en = 1'b1;
                end
                ST_SEND_HDR: begin
                    out_valid = 1'b1;
                    out_first = 1'b1;
                    out_data  = make_header(seq_lat, ctx_lat, CORE_ID);
                end
                ST_SEND_DATA: begin
                    out_valid = 1'b1;
                    out_last  = (rd_idx == LAST_IDX);
                    out_data  = ram_rdata;
                end
                default: begin
                    rd_en = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_output_recv.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_output_recv
// Brief    : Directed self-checking bench for core_output_recv.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_output_recv;

    localparam logic [7:0] TB_CORE_ID = 8'h5A;
    localparam int         N          = 16;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        core_out_ready;
    logic        core_out_ctx_num;
    logic        core_out_seq_num;
    logic        core_out_start;
    logic [15:0] core_dout;
    logic        rd_en;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_first;
    logic        out_last;
    logic        out_rd;
    logic        err;

    int errors = 0;
    int checks = 0;

    core_output_recv #(
        .CORE_ID (TB_CORE_ID),
        .N_WORDS (N)
    ) dut (
        .CLK              (CLK),
        .rst_n            (rst_n),
        .core_out_ready   (core_out_ready),
        .core_out_ctx_num (core_out_ctx_num),
        .core_out_seq_num (core_out_seq_num),
        .core_out_start   (core_out_start),
        .core_dout        (core_dout),
        .rd_en            (rd_en),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_first        (out_first),
        .out_last         (out_last),
        .out_rd           (out_rd),
        .err              (err)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; inputs are then driven and outputs sampled 1ns later
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Core-side model: wait for rd_en, hold ready for `hold` cycles after it,
    // pulse start `sdelay` cycles after it, then stream base..base+N-1.
    task automatic feed_packet(input logic ctx, input logic seq,
                               input logic [15:0] base, input int hold,
                               input int sdelay, input int abort_at,
                               output int rd_cnt);
        int guard;
        rd_cnt           = 0;
        guard            = 0;
        core_out_ready   = 1'b1;
        core_out_ctx_num = ctx;
        core_out_seq_num = seq;
        while (!rd_en && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (!rd_en) begin
            errors++;
            $display("FAIL rd_en_timeout: rd_en=%0b after %0d cycles, required 1", rd_en, guard);
            core_out_ready = 1'b0;
            return;
        end
        rd_cnt = 1;
        for (int k = 0; k <= sdelay; k++) begin
            core_out_ready   = (k <= hold);
            core_out_start   = (k == sdelay);
            // Scramble ctx/seq after the request: header must use latched values
            core_out_ctx_num = ~ctx;
            core_out_seq_num = ~seq;
            tick();
            if (rd_en) rd_cnt++;
        end
        core_out_ready = 1'b0;
        core_out_start = 1'b0;
        for (int w = 0; w < N; w++) begin
            if (w == abort_at) return;
            core_dout = base + 16'(w);
            tick();
            if (rd_en) rd_cnt++;
        end
        core_dout = 16'h0000;
    endtask

    // Downstream side: check header then every data word in order
    task automatic drain(input logic [15:0] hdr, input logic [15:0] base,
                         input bit rnd, input bit ready_at_end);
        int          idx;
        int          guard;
        logic [18:0] exp_v;
        logic [18:0] got_v;
        logic        exp_last;
        idx   = -1;
        guard = 0;
        while (idx < N && guard < 600) begin
            exp_last = (idx == N - 1);
            if (idx == -1) exp_v = {1'b1, 1'b1, 1'b0, hdr};
            else           exp_v = {1'b1, 1'b0, exp_last, base + 16'(idx)};
            got_v = {out_valid, out_first, out_last, out_data};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL drain_word idx=%0d: got {v,f,l,data}=%h required %h", idx, got_v, exp_v);
            end
            out_rd = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ready_at_end && idx == N - 1) core_out_ready = 1'b1;
            tick();
            if (out_rd) idx++;
            guard++;
        end
        out_rd = 1'b0;
        checks++;
        if (guard >= 600) begin
            errors++;
            $display("FAIL drain_timeout: delivered %0d words, required %0d", idx, N);
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        core_out_ready   = 1'b1;
        core_out_ctx_num = 1'b0;
        core_out_seq_num = 1'b0;
        core_out_start   = 1'b0;
        core_dout        = 16'h0000;
        out_rd           = 1'b0;
        tick();
        tick();
        checks++; if (rd_en !== 1'b0)     begin errors++; $display("FAIL reset_rd_en: got %b required 0", rd_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out_first !== 1'b0) begin errors++; $display("FAIL reset_out_first: got %b required 0", out_first); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_out_last: got %b required 0", out_last); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b required 0", err); end
        core_out_ready = 1'b0;
        rst_n          = 1'b1;
        tick();
        checks++; if ({rd_en, out_valid} !== 2'b00) begin errors++; $display("FAIL post_reset_idle: rd_en,out_valid got %b required 00", {rd_en, out_valid}); end
    endtask

    task automatic test_basic();
        int rc;
        feed_packet(1'b1, 1'b0, 16'h1000, 0, 3, -1, rc);
        checks++; if (rc !== 1) begin errors++; $display("FAIL basic_rd_en_count: got %0d required 1", rc); end
        drain(16'h4000 | {8'h00, TB_CORE_ID}, 16'h1000, 1'b0, 1'b0);
        checks++; if ({out_valid, rd_en, err} !== 3'b000) begin errors++; $display("FAIL basic_idle_after: valid,rd_en,err got %b required 000", {out_valid, rd_en, err}); end
    endtask

    task automatic test_backpressure();
        int rc;
        feed_packet(1'b0, 1'b1, 16'hA5A0, 0, 1, -1, rc);
        checks++; if (rc !== 1) begin errors++; $display("FAIL bp_rd_en_count: got %0d required 1", rc); end
        drain(16'h8000 | {8'h00, TB_CORE_ID}, 16'hA5A0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int rc;
        feed_packet(1'b0, 1'b0, 16'h3000, 2, 3, -1, rc);
        checks++; if (rc !== 1) begin errors++; $display("FAIL b2b_rd_en_count_1: got %0d required 1", rc); end
        core_out_ctx_num = 1'b1;
        core_out_seq_num = 1'b1;
        drain(16'h0000 | {8'h00, TB_CORE_ID}, 16'h3000, 1'b0, 1'b1);
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL b2b_gap_idle: rd_en got %b required 0", rd_en); end
        tick();
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL b2b_next_req: rd_en got %b required 1", rd_en); end
        feed_packet(1'b1, 1'b1, 16'h5000, 2, 4, -1, rc);
        checks++; if (rc !== 1) begin errors++; $display("FAIL b2b_rd_en_count_2: got %0d required 1", rc); end
        drain(16'hC000 | {8'h00, TB_CORE_ID}, 16'h5000, 1'b0, 1'b0);
    endtask

    task automatic test_err();
        core_out_start = 1'b1;
        tick();
        core_out_start = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b required 1", err); end
        tick();
        tick();
        tick();
        checks++; if ({err, out_valid, rd_en} !== 3'b100) begin errors++; $display("FAIL err_sticky_no_output: err,valid,rd_en got %b required 100", {err, out_valid, rd_en}); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared_by_reset: got %b required 0", err); end
    endtask

    task automatic test_reset_mid_packet();
        int rc;
        feed_packet(1'b1, 1'b1, 16'h7700, 0, 2, 7, rc);
        rst_n = 1'b0;
        tick();
        checks++; if ({rd_en, out_valid, out_first, out_last, err} !== 5'b00000) begin errors++; $display("FAIL midreset_outputs: got %b required 00000", {rd_en, out_valid, out_first, out_last, err}); end
        rst_n = 1'b1;
        tick();
        checks++; if ({rd_en, out_valid} !== 2'b00) begin errors++; $display("FAIL midreset_idle: rd_en,valid got %b required 00", {rd_en, out_valid}); end
        feed_packet(1'b1, 1'b0, 16'h2000, 0, 3, -1, rc);
        checks++; if (rc !== 1) begin errors++; $display("FAIL midreset_clean_rd_en: got %0d required 1", rc); end
        drain(16'h4000 | {8'h00, TB_CORE_ID}, 16'h2000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_err();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
